bus_timer: RTL and testbench
============================

Name: bus_timer

Overview:
Memory-mapped timer/counter peripheral that acts as the responder on the CPU data bus (m_data_addr/m_data_wdata/m_data_byteen/m_data_rdata). It decodes a 16-byte window, holds CTRL/PRESET/COUNT registers and counts down. On expiry it raises an interrupt line wired into one HWInt bit of the processor. The bridge muxes its rdata back onto m_data_rdata.

Parameters:
BASE_ADDR, 32'h0000_7F00, base of the 16-byte register window; bits [3:0] ignored.

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
addr  input  32  byte address from CPU M stage
wdata  input  32  write data, already lane-aligned by CPU byte-enable logic
byteen  input  4  per-byte write enables; any bit set with sel=1 means write
rdata  output  32  combinational read data for addr
sel  output  1  high when addr[31:4]==BASE_ADDR[31:4]
irq  output  1  interrupt request to HWInt

Behaviour:
- Register map (offset = addr[3:2]): 0 CTRL, 1 PRESET, 2 COUNT (read-only), 3 reserved (reads 0, writes ignored).
- CTRL bits: [0] EN, [2:1] MODE (0 one-shot, 1 auto-reload, 2/3 behave as 0), [3] IM (irq mask, 1 = enabled), [31:4] read 0.
- Writes: at the clk edge when sel && byteen!=0. Each byte lane i is updated only if byteen[i]; other lanes keep their value. Writes to COUNT and reserved offsets are ignored.
- Reads: combinational, same cycle as addr. rdata is 0 when sel=0.
- Reset: CTRL=0, PRESET=0, COUNT=0, state IDLE, irq_flag=0, irq=0, rdata=0 while sel=0.
- FSM states: IDLE, LOAD, CNT, INT.
  - IDLE: if EN -> LOAD.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT: if !EN -> IDLE, COUNT holds. Else if COUNT>1, COUNT<=COUNT-1. Else COUNT<=0, irq_flag<=1, -> INT.
  - INT, MODE 0: EN<=0, -> IDLE, irq_flag held.
  - INT, MODE 1: irq_flag<=0, -> LOAD (reload).
- irq = irq_flag && IM.
- irq_flag clears on any CPU write to CTRL.
- Latency: CTRL.EN written at edge 0 -> LOAD after edge 1 -> COUNT=PRESET after edge 2. For PRESET=P≥1, irq high after edge 2+P.
- PRESET=0 expires in the first CNT cycle, same timing as PRESET=1.
- Simultaneous CPU CTRL write and FSM EN clear in INT: the CPU write wins.
- PRESET written during CNT does not disturb COUNT; it takes effect at the next LOAD.
- Clearing EN mid-count freezes COUNT and returns to IDLE. Re-enabling reloads from PRESET.
- Reset mid-operation returns everything to reset values on that edge.

Optional Feature:
BUS_TIMER_PRESCALE_EN:
- Defined: offset 3 becomes a PRESCALE register (R/W, 16 bits, upper bits read 0). In CNT, COUNT decrements only when an internal prescale counter reaches PRESCALE. That counter then wraps to 0 and resets on LOAD. PRESCALE=0 gives the base behaviour.
- Undefined: offset 3 reserved; COUNT decrements every CNT cycle.

Decomposition:
- Shared package/header bus_timer_consts: register offsets, CTRL bit positions, MODE encodings, FSM state encodings, default BASE_ADDR.
- One sub-module, bus_timer_bytemerge: 32-bit old/new/byteen -> merged word (combinational), reused for CTRL, PRESET and PRESCALE.

Test Plan:
- Reset, then read offsets 0/4/8 -> rdata 0, irq 0; addr outside window -> sel 0, rdata 0.
- PRESET=5, CTRL=0x9 (EN, mode 0, IM) -> COUNT 5,4,3,2,1,0; irq rises 7 edges after CTRL write and stays high; EN reads 0; write CTRL=0 -> irq 0 next cycle.
- PRESET=3, CTRL=0xB (mode 1, IM) -> irq one-cycle pulse repeating every 5 cycles (INT, LOAD, 3 CNT).
- Write PRESET=0xFFFFFFFF then write 0x000000AA with byteen=4'b0001 -> PRESET reads 0xFFFFFFAA; write to COUNT ignored.
- Mid-count clear EN with COUNT=7 -> COUNT holds 7, state IDLE; re-enable -> reload from PRESET.
- Same-edge conflict: CPU writes CTRL=0x9 on the INT-mode-0 edge -> EN reads 1 and irq_flag cleared. With BUS_TIMER_PRESCALE_EN, PRESCALE=2 -> each COUNT step takes 3 cycles.

Source files
------------

// File: rtl/bus_timer_pkg.sv
// bus_timer_pkg: constants shared by the bus_timer slice.
//   Register offsets (word index, addr[3:2]), CTRL bit positions,
//   MODE encodings, FSM state type and the default register-window base.
package bus_timer_pkg;

    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0000_7F00;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    localparam int unsigned CTRL_EN  = 0;
    localparam int unsigned CTRL_IM  = 3;
    localparam int unsigned CTRL_W   = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'd0;
    localparam logic [1:0] MODE_RELOAD  = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    // MODE 2/3 fall back to one-shot, so only the exact reload code reloads.
    function automatic logic is_reload(input logic [CTRL_W-1:0] ctrl);
        return ctrl[2:1] == MODE_RELOAD;
    endfunction

endpackage

// File: rtl/bus_timer_bytemerge.sv
// bus_timer_bytemerge: per-byte write merge.
//   old_i    : current register value
//   new_i    : lane-aligned write data
//   byteen_i : byte lane enables
//   merged_o : old_i with each enabled lane replaced from new_i
module bus_timer_bytemerge (
    input  logic [31:0] old_i,
    input  logic [31:0] new_i,
    input  logic [3:0]  byteen_i,
    output logic [31:0] merged_o
);

    always_comb begin
        merged_o = old_i;
        for (int unsigned i = 0; i < 4; i++) begin
            if (byteen_i[i]) begin
                merged_o[8*i +: 8] = new_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped down-counting timer on the CPU data bus.
//   clk, reset : clock, synchronous active-high reset
//   addr       : byte address; window selected by addr[31:4]
//   wdata      : lane-aligned write data
//   byteen     : byte enables; any set bit while sel is a write
//   rdata      : combinational read data (0 when not selected)
//   sel        : address falls in the 16-byte window at BASE_ADDR
//   irq        : interrupt request (expiry flag gated by CTRL.IM)
// Optional feature macro BUS_TIMER_PRESCALE_EN turns offset 3 into a
// 16-bit PRESCALE register that slows COUNT decrements.
module bus_timer
    import bus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] rdata,
    output logic        sel,
    output logic        irq
);

    state_e              state_q, state_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [31:0]         preset_q, preset_d;
    logic [31:0]         count_q, count_d;
    logic                irq_flag_q, irq_flag_d;
    logic [31:0]         ctrl_merged, preset_merged;
    logic [1:0]          off;
    logic                wr;
    logic                tick;

    assign sel = (addr[31:4] == BASE_ADDR[31:4]);
    assign off = addr[3:2];
    assign wr  = sel && (byteen != '0);
    assign irq = irq_flag_q && ctrl_q[CTRL_IM];

    bus_timer_bytemerge u_ctrl_merge (
        .old_i    ({{(32-CTRL_W){1'b0}}, ctrl_q}),
        .new_i    (wdata),
        .byteen_i (byteen),
        .merged_o (ctrl_merged)
    );

    bus_timer_bytemerge u_preset_merge (
        .old_i    (preset_q),
        .new_i    (wdata),
        .byteen_i (byteen),
        .merged_o (preset_merged)
    );

`ifdef BUS_TIMER_PRESCALE_EN
    logic [15:0] psc_q, psc_d;
    logic [15:0] pcnt_q, pcnt_d;
    logic [31:0] psc_merged;

    bus_timer_bytemerge u_psc_merge (
        .old_i    ({16'b0, psc_q}),
        .new_i    (wdata),
        .byteen_i (byteen),
        .merged_o (psc_merged)
    );

    // >= rather than == so a PRESCALE lowered mid-count cannot strand the
    // counter above it for a full 16-bit wrap.
    assign tick = (pcnt_q >= psc_q);

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], ctrl_merged[31:CTRL_W], psc_merged[31:16]};
`else
    assign tick = 1'b1;

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], ctrl_merged[31:CTRL_W]};
`endif

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;
`ifdef BUS_TIMER_PRESCALE_EN
        psc_d      = psc_q;
        pcnt_d     = pcnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q[CTRL_EN]) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
`ifdef BUS_TIMER_PRESCALE_EN
                pcnt_d  = '0;
`endif
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
`ifdef BUS_TIMER_PRESCALE_EN
                    pcnt_d = '0;
`endif
                    if (count_q > 32'd1) begin
                        count_d = count_q - 32'd1;
                    end else begin
                        // PRESET=0 lands here too, expiring like PRESET=1.
                        count_d    = '0;
                        irq_flag_d = 1'b1;
                        state_d    = ST_INT;
                    end
                end else begin
`ifdef BUS_TIMER_PRESCALE_EN
                    pcnt_d = pcnt_q + 16'd1;
`endif
                end
            end
            ST_INT: begin
                if (is_reload(ctrl_q)) begin
                    irq_flag_d = 1'b0;
                    state_d    = ST_LOAD;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // CPU writes are applied after the FSM so they override its EN clear.
        if (wr) begin
            if (off == OFF_CTRL) begin
                ctrl_d     = ctrl_merged[CTRL_W-1:0];
                irq_flag_d = 1'b0;
            end
            if (off == OFF_PRESET) preset_d = preset_merged;
`ifdef BUS_TIMER_PRESCALE_EN
            if (off == OFF_RSVD) psc_d = psc_merged[15:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
`ifdef BUS_TIMER_PRESCALE_EN
            psc_q      <= '0;
            pcnt_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
`ifdef BUS_TIMER_PRESCALE_EN
            psc_q      <= psc_d;
            pcnt_q     <= pcnt_d;
`endif
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
`ifdef BUS_TIMER_PRESCALE_EN
                default:    rdata = {16'b0, psc_q};
`else
                default:    rdata = '0;
`endif
            endcase
        end
    end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed self-checking bench for bus_timer.
module tb_bus_timer;

    localparam logic [31:0] BASE = 32'h0000_7F00;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        sel;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bus_timer #(.BASE_ADDR(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .wdata  (wdata),
        .byteen (byteen),
        .rdata  (rdata),
        .sel    (sel),
        .irq    (irq)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] be);
        addr   = BASE + off;
        wdata  = data;
        byteen = be;
        @(posedge clk);
        #1;
        byteen = '0;
        wdata  = '0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data);
        addr = BASE + off;
        #1;
        data = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        reset = 1'b1; addr = '0; wdata = '0; byteen = '0;
        step(); step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd(32'(4*i), v);
            n_vec++;
            if (v !== 32'h0) begin n_err++; $display("FAIL reset_rd%0d: got %h want 0", 4*i, v); end
        end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
        n_vec++;
        if (sel !== 1'b1) begin n_err++; $display("FAIL sel_in: got %b want 1", sel); end
        addr = 32'h0000_1004;
        #1;
        n_vec++;
        if (sel !== 1'b0 || rdata !== 32'h0) begin
            n_err++; $display("FAIL sel_out: got sel=%b rdata=%h want sel=0 rdata=0", sel, rdata);
        end
    endtask

    task automatic test_oneshot();
        logic [31:0] v, exp_c;
        logic        exp_i;
        wr(4, 32'd5, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_c = (k < 2) ? 32'd0 : (k >= 7) ? 32'd0 : 32'(7 - k);
            exp_i = (k >= 7);
            rd(8, v);
            n_vec++;
            if (v !== exp_c) begin n_err++; $display("FAIL oneshot_count_e%0d: got %0d want %0d", k, v, exp_c); end
            n_vec++;
            if (irq !== exp_i) begin n_err++; $display("FAIL oneshot_irq_e%0d: got %b want %b", k, irq, exp_i); end
        end
        rd(0, v);
        n_vec++;
        if (v !== 32'h8) begin n_err++; $display("FAIL oneshot_en_clr: got %h want 8", v); end
        wr(0, 32'h0, 4'hF);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL oneshot_irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_preset_zero();
        wr(4, 32'd0, 4'hF);
        wr(0, 32'h9, 4'hF);
        step(); step();
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL p0_irq_e2: got %b want 0", irq); end
        step();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL p0_irq_e3: got %b want 1", irq); end
        wr(0, 32'h0, 4'hF);
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL p0_irq_clr: got %b want 0", irq); end
    endtask

    task automatic test_reload();
        logic [31:0] v;
        logic        exp_i;
        wr(4, 32'd3, 4'hF);
        wr(0, 32'hB, 4'hF);
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_i = (k % 5 == 0);
            n_vec++;
            if (irq !== exp_i) begin n_err++; $display("FAIL reload_irq_e%0d: got %b want %b", k, irq, exp_i); end
        end
        wr(0, 32'h0, 4'hF);
        step(); step(); step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd3 || irq !== 1'b0) begin
            n_err++; $display("FAIL reload_stop: got count=%0d irq=%b want count=3 irq=0", v, irq);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] v;
        wr(4, 32'hFFFF_FFFF, 4'hF);
        rd(4, v);
        n_vec++;
        if (v !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL bl_full: got %h want ffffffff", v); end
        wr(4, 32'h0000_00AA, 4'b0001);
        rd(4, v);
        n_vec++;
        if (v !== 32'hFFFF_FFAA) begin n_err++; $display("FAIL bl_lane0: got %h want ffffffaa", v); end
        wr(4, 32'h0012_0000, 4'b0100);
        rd(4, v);
        n_vec++;
        if (v !== 32'hFF12_FFAA) begin n_err++; $display("FAIL bl_lane2: got %h want ff12ffaa", v); end
        wr(8, 32'h0000_0055, 4'hF);
        rd(8, v);
        n_vec++;
        if (v !== 32'd3) begin n_err++; $display("FAIL bl_count_ro: got %h want 3", v); end
        wr(0, 32'hFFFF_FFF0, 4'hF);
        rd(0, v);
        n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL bl_ctrl_hi: got %h want 0", v); end
        wr(12, 32'hDEAD_BEEF, 4'hF);
        rd(12, v);
        n_vec++;
`ifdef BUS_TIMER_PRESCALE_EN
        if (v !== 32'h0000_BEEF) begin n_err++; $display("FAIL bl_off3: got %h want 0000beef", v); end
        wr(12, 32'h0, 4'hF);
`else
        if (v !== 32'h0) begin n_err++; $display("FAIL bl_off3: got %h want 0", v); end
`endif
    endtask

    task automatic test_mid_clear();
        logic [31:0] v;
        wr(4, 32'd10, 4'hF);
        wr(0, 32'h1, 4'hF);
        step(); step(); step(); step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd8) begin n_err++; $display("FAIL mc_count8: got %0d want 8", v); end
        wr(0, 32'h0, 4'hF);
        step(); step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd7) begin n_err++; $display("FAIL mc_hold7: got %0d want 7", v); end
        wr(0, 32'h1, 4'hF);
        step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd7) begin n_err++; $display("FAIL mc_load_e1: got %0d want 7", v); end
        step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd10) begin n_err++; $display("FAIL mc_reload: got %0d want 10", v); end
        wr(4, 32'd20, 4'hF);
        rd(8, v);
        n_vec++;
        if (v !== 32'd9) begin n_err++; $display("FAIL mc_preset_live: got %0d want 9", v); end
        rd(4, v);
        n_vec++;
        if (v !== 32'd20) begin n_err++; $display("FAIL mc_preset_rd: got %0d want 20", v); end
        wr(8, 32'h55, 4'hF);
        rd(8, v);
        n_vec++;
        if (v !== 32'd8) begin n_err++; $display("FAIL mc_count_wr: got %0d want 8", v); end
        wr(0, 32'h0, 4'hF);
        step();
    endtask

    task automatic test_conflict();
        logic [31:0] v;
        wr(4, 32'd2, 4'hF);
        wr(0, 32'h9, 4'hF);
        step(); step(); step(); step();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL cf_irq_set: got %b want 1", irq); end
        wr(0, 32'h9, 4'hF);
        rd(0, v);
        n_vec++;
        if (v !== 32'h9) begin n_err++; $display("FAIL cf_ctrl_wins: got %h want 9", v); end
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL cf_irq_clr: got %b want 0", irq); end
        step(); step();
        rd(8, v);
        n_vec++;
        if (v !== 32'd2) begin n_err++; $display("FAIL cf_restart: got %0d want 2", v); end
        step(); step();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL cf_irq_again: got %b want 1", irq); end
        wr(0, 32'h0, 4'hF);
    endtask

    task automatic test_mid_reset();
        logic [31:0] v;
        wr(4, 32'd5, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 0; k < 7; k++) step();
        n_vec++;
        if (irq !== 1'b1) begin n_err++; $display("FAIL mr_irq_pre: got %b want 1", irq); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++;
        if (irq !== 1'b0) begin n_err++; $display("FAIL mr_irq: got %b want 0", irq); end
        for (int i = 0; i < 3; i++) begin
            rd(32'(4*i), v);
            n_vec++;
            if (v !== 32'h0) begin n_err++; $display("FAIL mr_rd%0d: got %h want 0", 4*i, v); end
        end
    endtask

`ifdef BUS_TIMER_PRESCALE_EN
    task automatic test_prescale();
        logic [31:0] v, exp_c;
        logic        exp_i;
        wr(12, 32'd2, 4'hF);
        wr(4, 32'd2, 4'hF);
        wr(0, 32'h9, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            step();
            exp_c = (k < 2) ? 32'd0 : (k <= 4) ? 32'd2 : (k <= 7) ? 32'd1 : 32'd0;
            exp_i = (k >= 8);
            rd(8, v);
            n_vec++;
            if (v !== exp_c) begin n_err++; $display("FAIL psc_count_e%0d: got %0d want %0d", k, v, exp_c); end
            n_vec++;
            if (irq !== exp_i) begin n_err++; $display("FAIL psc_irq_e%0d: got %b want %b", k, irq, exp_i); end
        end
        wr(0, 32'h0, 4'hF);
        wr(12, 32'hFFFF_FFFF, 4'hF);
        rd(12, v);
        n_vec++;
        if (v !== 32'h0000_FFFF) begin n_err++; $display("FAIL psc_width: got %h want 0000ffff", v); end
    endtask
`endif

    initial begin
        test_reset();
        test_oneshot();
        test_preset_zero();
        test_reload();
        test_byte_lanes();
        test_mid_clear();
        test_conflict();
        test_mid_reset();
`ifdef BUS_TIMER_PRESCALE_EN
        test_prescale();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
